// File: rtl/matrix_mult_seq.sv
// Sequential signed fixed-point NxN matrix multiplier (C = A*B or A*B^T), one MAC per clock,
// with round-half-up output scaling and saturation to DW bits.
module matrix_mult_seq #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int SHIFT = 0
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                Enable,
  input  logic                transpose_b,
  input  logic [N*N*DW-1:0]   A,
  input  logic [N*N*DW-1:0]   B,
  output logic [N*N*DW-1:0]   C,
  output logic                busy,
  output logic                done
);

  generate
    if (ACC_W < 2*DW + $clog2(N)) begin : g_acc_w_check
      $error("matrix_mult_seq: ACC_W too small for 2*DW+clog2(N)");
    end
    if (SHIFT < 0 || SHIFT > ACC_W-2) begin : g_shift_check
      $error("matrix_mult_seq: SHIFT out of range");
    end
  endgenerate

  localparam int IW = $clog2(N);
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            i, j, k;
  logic                     tr_q;
  logic signed [DW-1:0]     a_m [N][N];
  logic signed [DW-1:0]     b_m [N][N];
  logic signed [DW-1:0]     c_m [N][N];
  logic signed [ACC_W-1:0]  acc, sum;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W:0]    rnd, shd;
  logic signed [DW-1:0]     res;
  logic                     last_k, last_j, last_i;

  always_comb begin
    last_k = (k == IW'(N-1));
    last_j = (j == IW'(N-1));
    last_i = (i == IW'(N-1));
    prod   = a_m[i][k] * (tr_q ? b_m[j][k] : b_m[k][j]);
    sum    = acc + ACC_W'(prod);
    // one extra bit so adding the rounding constant can never wrap
    rnd    = (ACC_W+1)'(sum) + RND;
    shd    = rnd >>> SHIFT;
    if (shd > MAXV)      res = MAXV[DW-1:0];
    else if (shd < MINV) res = MINV[DW-1:0];
    else                 res = shd[DW-1:0];
  end

  always_ff @(posedge Clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = COMPUTE;
      COMPUTE: if (last_k && last_j && last_i) state_nxt = DONE;
      DONE:    if (!Enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == COMPUTE);
  assign done = (state == DONE);

  always_ff @(posedge Clock) begin
    if (reset) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      acc  <= '0;
      tr_q <= 1'b0;
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned c = 0; c < N; c++)
          c_m[r][c] <= '0;
    end else begin
      case (state)
        IDLE: if (Enable) begin
          for (int unsigned r = 0; r < N; r++)
            for (int unsigned c = 0; c < N; c++) begin
              a_m[r][c] <= A[(r*N+c)*DW +: DW];
              b_m[r][c] <= B[(r*N+c)*DW +: DW];
            end
          tr_q <= transpose_b;
          i    <= '0;
          j    <= '0;
          k    <= '0;
          acc  <= '0;
        end
        COMPUTE: begin
          if (last_k) begin
            c_m[i][j] <= res;
            acc       <= '0;
            k         <= '0;
            if (last_j) begin
              j <= '0;
              i <= last_i ? '0 : i + IW'(1);
            end else begin
              j <= j + IW'(1);
            end
          end else begin
            acc <= sum;
            k   <= k + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    C = '0;
    for (int unsigned r = 0; r < N; r++)
      for (int unsigned c = 0; c < N; c++)
        C[(r*N+c)*DW +: DW] = c_m[r][c];
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Randomised and directed bench for matrix_mult_seq: three N=8 instances (SHIFT 0/1/4) and one N=2
// instance share control; results are compared against a plain-arithmetic matrix model.
module tb_matrix_mult_seq;

  logic          Clock = 1'b0;
  logic          reset, Enable, transpose_b;
  logic [1023:0] A8, B8, Ca, Cb, Cc;
  logic [63:0]   A2, B2, Cd;
  logic          busy_a, busy_b, busy_c, busy_d;
  logic          done_a, done_b, done_c, done_d;

  int checks = 0;
  int errors = 0;
  longint am [8][8];
  longint bm [8][8];

  always #5 Clock = ~Clock;

  matrix_mult_seq #(.N(8), .DW(16), .ACC_W(40), .SHIFT(0)) ua (
    .Clock(Clock), .reset(reset), .Enable(Enable), .transpose_b(transpose_b),
    .A(A8), .B(B8), .C(Ca), .busy(busy_a), .done(done_a));
  matrix_mult_seq #(.N(8), .DW(16), .ACC_W(40), .SHIFT(1)) ub (
    .Clock(Clock), .reset(reset), .Enable(Enable), .transpose_b(transpose_b),
    .A(A8), .B(B8), .C(Cb), .busy(busy_b), .done(done_b));
  matrix_mult_seq #(.N(8), .DW(16), .ACC_W(40), .SHIFT(4)) uc (
    .Clock(Clock), .reset(reset), .Enable(Enable), .transpose_b(transpose_b),
    .A(A8), .B(B8), .C(Cc), .busy(busy_c), .done(done_c));
  matrix_mult_seq #(.N(2), .DW(16), .ACC_W(40), .SHIFT(0)) ud (
    .Clock(Clock), .reset(reset), .Enable(Enable), .transpose_b(transpose_b),
    .A(A2), .B(B2), .C(Cd), .busy(busy_d), .done(done_d));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_el(input int n, input int sh, input bit tr, input int r, input int c);
    longint s = 0;
    for (int kk = 0; kk < n; kk++)
      s += am[r][kk] * (tr ? bm[c][kk] : bm[kk][c]);
    if (sh > 0) s += longint'(1) <<< (sh - 1);
    s = s >>> sh;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic cmp_mat(input string tag, input logic [1023:0] bus, input int n, input int sh, input bit tr);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        check($sformatf("%s_C[%0d][%0d]", tag, r, c),
              longint'($signed(bus[(r*n+c)*16 +: 16])), ref_el(n, sh, tr, r, c));
  endtask

  // modes: 0 constant, 1 identity, 2 ramp r*8+c, 3 random signed 16-bit
  function automatic longint gen(input int mode, input longint val, input int r, input int c);
    case (mode)
      0: return val;
      1: return (r == c) ? 1 : 0;
      2: return longint'(r*8 + c);
      default: return longint'($signed(16'($urandom)));
    endcase
  endfunction

  task automatic fill(input int amode, input longint aval, input int bmode, input longint bval);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        am[r][c] = gen(amode, aval, r, c);
        bm[r][c] = gen(bmode, bval, r, c);
      end
  endtask

  task automatic pack();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        A8[(r*8+c)*16 +: 16] = am[r][c][15:0];
        B8[(r*8+c)*16 +: 16] = bm[r][c][15:0];
        if (r < 2 && c < 2) begin
          A2[(r*2+c)*16 +: 16] = am[r][c][15:0];
          B2[(r*2+c)*16 +: 16] = bm[r][c][15:0];
        end
      end
  endtask

  task automatic run(input string tag, input bit tr, input int drop_at, input int rst_at);
    int cnt = 0;
    int cntd = 0;
    int bad = 0;
    pack();
    transpose_b = tr;
    Enable = 1'b1;
    @(posedge Clock); #1;
    check({tag, "_busy_e0"}, longint'(busy_a), 1);
    check({tag, "_done_e0"}, longint'(done_a), 0);
    // scramble operands after the start edge; results must not change
    for (int w = 0; w < 32; w++) begin
      A8[w*32 +: 32] = $urandom;
      B8[w*32 +: 32] = $urandom;
    end
    A2 = {$urandom, $urandom};
    B2 = {$urandom, $urandom};
    transpose_b = ~tr;
    while (!done_a && cnt < 1000) begin
      @(posedge Clock); #1;
      cnt++;
      if (done_d && cntd == 0) cntd = cnt;
      if (!done_a && busy_a !== 1'b1) bad++;
      if (busy_a && done_a) bad++;
      if (cnt == drop_at) Enable = 1'b0;
      if (cnt == rst_at) begin
        reset  = 1'b1;
        Enable = 1'b0;
        @(posedge Clock); #1;
        check({tag, "_rst_busy"}, longint'(busy_a), 0);
        check({tag, "_rst_done"}, longint'(done_a), 0);
        check({tag, "_rst_C_ones"}, longint'($countones(Ca)), 0);
        reset = 1'b0;
        @(posedge Clock); #1;
        return;
      end
    end
    check({tag, "_latency"}, longint'(cnt), 512);
    check({tag, "_latency_n2"}, longint'(cntd), 8);
    check({tag, "_busy_run"}, longint'(bad), 0);
    check({tag, "_busy_at_done"}, longint'(busy_a), 0);
    cmp_mat({tag, "_s0"}, Ca, 8, 0, tr);
    cmp_mat({tag, "_s1"}, Cb, 8, 1, tr);
    cmp_mat({tag, "_s4"}, Cc, 8, 4, tr);
    cmp_mat({tag, "_n2"}, {960'b0, Cd}, 2, 0, tr);
    if (drop_at > 0) begin
      @(posedge Clock); #1;
      check({tag, "_done_one_cycle"}, longint'(done_a), 0);
    end else begin
      repeat (3) begin
        @(posedge Clock); #1;
        check({tag, "_done_held"}, longint'(done_a), 1);
        check({tag, "_no_rerun"}, longint'(busy_a), 0);
      end
      Enable = 1'b0;
      @(posedge Clock); #1;
      check({tag, "_done_clear"}, longint'(done_a), 0);
      @(posedge Clock); #1;
      check({tag, "_idle"}, longint'(busy_a), 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    Enable = 1'b0;
    transpose_b = 1'b0;
    fill(0, 0, 0, 0);
    pack();
    repeat (2) @(posedge Clock);
    #1;
    check("reset_busy", longint'(busy_a), 0);
    check("reset_done", longint'(done_a), 0);
    check("reset_C_ones", longint'($countones(Ca)), 0);
    check("reset_busy_n2", longint'(busy_d), 0);
    reset = 1'b0;
    @(posedge Clock); #1;
    check("idle_busy", longint'(busy_a), 0);

    fill(1, 0, 2, 0);           run("ident_ramp", 0, -1, -1);
    fill(0, 2, 0, 3);           run("twos_threes", 0, -1, -1);
    check("shift4_elem", longint'($signed(Cc[15:0])), 3);
    fill(1, 0, 0, 3);           run("round_pos", 0, -1, -1);
    check("shift1_pos", longint'($signed(Cb[15:0])), 2);
    fill(1, 0, 0, -3);          run("round_neg", 0, -1, -1);
    check("shift1_neg", longint'($signed(Cb[15:0])), -1);
    fill(0, 32767, 0, 32767);   run("sat_pos", 0, -1, -1);
    check("sat_pos_elem", longint'($signed(Ca[15:0])), 32767);
    fill(0, 32767, 0, -32768);  run("sat_neg", 0, -1, -1);
    check("sat_neg_elem", longint'($signed(Ca[15:0])), -32768);

    fill(1, 0, 3, 0);
    bm[0][0] = 1; bm[0][1] = 2; bm[1][0] = 3; bm[1][1] = 4;
    run("n2_trans", 1, -1, -1);
    check("n2_trans_01", longint'($signed(Cd[31:16])), 3);
    run("n2_plain", 0, -1, -1);
    check("n2_plain_01", longint'($signed(Cd[31:16])), 2);

    fill(1, 0, 2, 0);
    run("midrun_reset", 0, -1, 100);
    run("after_reset", 0, -1, -1);
    run("drop_enable", 0, 50, -1);

    repeat (3) begin
      fill(3, 0, 3, 0);
      run("random", 1'($urandom), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
